// File: rtl/stream_border_detect.sv
// stream_border_detect
//   Streaming 3x3 morphological-gradient border detector. One pixel per cycle
//   in raster order. Two WIDTH-deep line buffers hold the previous two rows,
//   so a 3x3 window is formed on the fly. Each output is the window max minus
//   the window min. The output is either that raw gradient or a binarised edge
//   map, and the choice is made per frame.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    pixel present this cycle (no backpressure)
//   in_sof      with in_valid: pixel is row 0, col 0 of a new frame
//   in_pix      input pixel
//   mode_bin    0 = raw gradient, 1 = binarised; latched on accepted in_sof
//   out_valid   output pixel valid
//   out_sol     with out_valid: first output pixel of an output row
//   out_pix     gradient or binary pixel
//   frame_done  pulse with the last output pixel of a frame
module stream_border_detect #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int PIX_W     = 8,
  parameter int THRESHOLD = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             mode_bin,
  output logic             out_valid,
  output logic             out_sol,
  output logic [PIX_W-1:0] out_pix,
  output logic             frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          mode_q, mode_d;
  logic          complete;

  // An accepted in_sof overrides the counters, so a restart can happen at any point.
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    if (in_valid) begin
      if (in_sof) mode_d = mode_bin;
      if (cur_col == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  assign complete = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
    end
  end

  // Line buffers: lb1 holds row r-1 and lb2 holds row r-2. Both are read
  // before they are written at the same column. The window columns shift
  // only on accepted pixels.
  logic [PIX_W-1:0] lb1_mem [WIDTH];
  logic [PIX_W-1:0] lb2_mem [WIDTH];
  logic [PIX_W-1:0] win_q   [3][3];   // [row: 0=r-2, 1=r-1, 2=r][col: 0=oldest]
  logic [PIX_W-1:0] rd1, rd2;

  assign rd1 = lb1_mem[cur_col];
  assign rd2 = lb2_mem[cur_col];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_mem[cur_col] <= in_pix;
      lb2_mem[cur_col] <= rd1;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= rd2;
      win_q[1][2] <= rd1;
      win_q[2][2] <= in_pix;
    end
  end

  // Stage 1 tags the window that has just been captured. The mode is carried
  // along with the tag, so outputs still in flight keep their own frame's mode.
  logic v1_q, sol1_q, done1_q, mode1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sol1_q  <= 1'b0;
      done1_q <= 1'b0;
      mode1_q <= 1'b0;
    end else begin
      v1_q    <= complete;
      sol1_q  <= complete && (cur_col == CW'(2));
      done1_q <= complete && (cur_row == RW'(HEIGHT - 1)) && (cur_col == CW'(WIDTH - 1));
      mode1_q <= mode_q;
    end
  end

  logic [PIX_W-1:0] mx, mn, grad, res;

  always_comb begin
    mx = win_q[0][0];
    mn = win_q[0][0];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (win_q[i][j] > mx) mx = win_q[i][j];
        if (win_q[i][j] < mn) mn = win_q[i][j];
      end
    end
    grad = mx - mn;
    if (mode1_q) res = (int'(grad) >= THRESHOLD) ? '1 : '0;
    else         res = grad;
  end

  logic             out_valid_q, out_sol_q, frame_done_q;
  logic [PIX_W-1:0] out_pix_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      out_pix_q    <= '0;
    end else begin
      out_valid_q  <= v1_q;
      out_sol_q    <= v1_q && sol1_q;
      frame_done_q <= v1_q && done1_q;
      out_pix_q    <= v1_q ? res : '0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sol    = out_sol_q;
  assign frame_done = frame_done_q;
  assign out_pix    = out_pix_q;

endmodule

// File: tb/tb_stream_border_detect.sv
module tb_stream_border_detect;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sof, mode_bin;
  logic [7:0] in_pix;
  logic       ov   [3];
  logic       osol [3];
  logic       fd   [3];
  logic [7:0] opix [3];

  always #5 clk = ~clk;

  stream_border_detect #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .THRESHOLD(200)) u_dut200 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .mode_bin(mode_bin), .out_valid(ov[0]), .out_sol(osol[0]), .out_pix(opix[0]),
    .frame_done(fd[0]));
  stream_border_detect #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .THRESHOLD(240)) u_dut240 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .mode_bin(mode_bin), .out_valid(ov[1]), .out_sol(osol[1]), .out_pix(opix[1]),
    .frame_done(fd[1]));
  stream_border_detect #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .THRESHOLD(241)) u_dut241 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .mode_bin(mode_bin), .out_valid(ov[2]), .out_sol(osol[2]), .out_pix(opix[2]),
    .frame_done(fd[2]));

  // Frame vectors: pattern, mode, gaps, sof, and the expected output row
  // (centre cols 1..6) for the DUTs with thresholds 200, 240 and 241.
  typedef struct {
    int                    pat;
    bit                    mode;
    bit                    gaps;
    bit                    sof;
    logic [0:2][0:5][7:0]  exp;
  } vec_t;

  typedef struct {
    int              due;
    bit              sol;
    bit              done;
    logic [0:2][7:0] pix;
  } sb_t;

  localparam logic [0:5][7:0] Z    = '0;
  localparam logic [0:5][7:0] SRAW = {8'd0, 8'd0, 8'd240, 8'd240, 8'd0, 8'd0};
  localparam logic [0:5][7:0] SBIN = {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
  localparam logic [0:5][7:0] R30  = {6{8'd30}};

  vec_t vec [7];
  sb_t  q [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_sol, n_done, first_cyc, last_sof_cyc;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] pixval(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd10 : 8'd250;
      default: return 8'(10 * c + 5 * r);
    endcase
  endfunction

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Sends a frame from vec[idx]. It stops before driving pixel
  // (stop_r, stop_c), which lets a test abort a frame part-way.
  task automatic send_frame(input int idx, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (vec[idx].gaps) repeat ($urandom_range(0, 2)) idle();
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = (r == 0 && c == 0) && vec[idx].sof;
        // mode_bin is driven inverted off in_sof, so a DUT sampling it there is caught
        mode_bin = in_sof ? vec[idx].mode : ~vec[idx].mode;
        in_pix   = pixval(vec[idx].pat, r, c);
        if (in_sof) last_sof_cyc = cyc;
        if (r >= 2 && c >= 2)
          q.push_back('{due: cyc + 2, sol: (c == 2), done: (r == H - 1 && c == W - 1),
                        pix: {vec[idx].exp[0][c-2], vec[idx].exp[1][c-2], vec[idx].exp[2][c-2]}});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (osol[0] === 1'b1) n_sol++;
      if (fd[0] === 1'b1) n_done++;
      if (ov[0] === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_output due=%0d now=%0d", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        sb_t e;
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (ov[k] !== 1'b1 || osol[k] !== e.sol || fd[k] !== e.done || opix[k] !== e.pix[k]) begin
            errors++;
            $display("FAIL output dut%0d cyc=%0d got v=%0b sol=%0b done=%0b pix=%0d exp v=1 sol=%0b done=%0b pix=%0d",
                     k, cyc, ov[k], osol[k], fd[k], opix[k], e.sol, e.done, e.pix[k]);
          end
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (ov[k] !== 1'b0) begin
            errors++;
            $display("FAIL unexpected_valid dut%0d cyc=%0d got v=%0b exp v=0", k, cyc, ov[k]);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || osol[k] !== 1'b0 || fd[k] !== 1'b0 || opix[k] !== 8'd0) begin
        errors++;
        $display("FAIL %s dut%0d got v=%0b sol=%0b done=%0b pix=%0d exp all 0",
                 name, k, ov[k], osol[k], fd[k], opix[k]);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  initial begin
    vec[0] = '{pat: 0, mode: 0, gaps: 0, sof: 1, exp: {Z, Z, Z}};
    vec[1] = '{pat: 1, mode: 0, gaps: 0, sof: 1, exp: {SRAW, SRAW, SRAW}};
    vec[2] = '{pat: 1, mode: 1, gaps: 0, sof: 1, exp: {SBIN, SBIN, Z}};
    vec[3] = '{pat: 1, mode: 1, gaps: 1, sof: 1, exp: {SBIN, SBIN, Z}};
    vec[4] = '{pat: 1, mode: 0, gaps: 1, sof: 1, exp: {SRAW, SRAW, SRAW}};
    vec[5] = '{pat: 2, mode: 0, gaps: 0, sof: 0, exp: {R30, R30, R30}};
    vec[6] = '{pat: 2, mode: 1, gaps: 1, sof: 1, exp: {Z, Z, Z}};

    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; mode_bin = 1'b0; in_pix = '0;
    first_cyc = -1; n_sol = 0; n_done = 0; last_sof_cyc = 0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Uniform frame: zeros, marker counts and first-output latency
    n_sol = 0; n_done = 0; first_cyc = -1;
    send_frame(0, -1, -1);
    repeat (6) idle();
    check_int("uniform_sol_count", n_sol, 4);
    check_int("uniform_done_count", n_done, 1);
    check_int("first_out_latency", first_cyc - last_sof_cyc, 20);

    // Table frames back-to-back; entry 5 continues without in_sof
    for (int i = 1; i < 7; i++) send_frame(i, -1, -1);
    repeat (4) idle();

    // Mid-frame restart: A (raw) aborted at (3,5), then B (binary) in full
    send_frame(1, 3, 5);
    send_frame(2, -1, -1);
    repeat (4) idle();

    // Asynchronous reset mid-frame, then a fresh frame
    send_frame(4, 3, 3);
    idle();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_frame(2, -1, -1);
    repeat (6) idle();
    check_int("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
